// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] last, last_n;
  logic [IW-1:0] base, win, idx;
  logic [BW-1:0] beats, beats_n;
  logic          found, own_req, rel;

  // In BURST a release sets last to owner, so scanning from owner matches.
  assign base = (state == BURST) ? owner : last;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(base) + k) % NREQ);
      if (req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign own_req = req[owner];
  assign busy    = (state == BURST) & ~wrst;
  assign winc    = busy & own_req & ~wfull;
  assign rel     = ~own_req | (winc & (beats == LAST_BEAT));

  assign grant = busy ? (NREQ'(1) << owner) : '0;
  assign ack   = winc ? (NREQ'(1) << owner) : '0;
  assign wdata = busy ? req_data[owner*DSIZE +: DSIZE] : '0;

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    beats_n = beats;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BURST;
          owner_n = win;
          beats_n = '0;
        end
      end
      BURST: begin
        if (winc)
          beats_n = beats + BW'(1);
        if (rel) begin
          last_n = owner;
          if (found) begin
            owner_n = win;
            beats_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      beats <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      beats <= beats_n;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge wclk) begin
    if (wrst)
      stall_cnt <= '0;
    else if (busy & own_req & wfull & (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. It sits entirely in the write-clock domain and shares the FIFO's single write port (`winc`/`wdata`/`wfull`) between NREQ requesters. Grants are handed out as bounded bursts. The arbiter guarantees that no write is issued while `wfull` is high.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DSIZE`, 8: data width; matches the FIFO `DSIZE`.
- `MAX_BURST`, 4: maximum accepted words per grant (1..15).

Ports:
- `wclk`  in  1: write clock; the only clock.
- `wrst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester valid; `req[i]` is held while `req_data` slice i is valid.
- `req_data`  in  NREQ*DSIZE: flattened data; requester i owns bits `[i*DSIZE +: DSIZE]`.
- `ack`  out  NREQ: one-hot pulse; the owner's word was written this cycle.
- `grant`  out  NREQ: one-hot registered owner; all zero when idle.
- `busy`  out  1: high while in BURST.
- `wfull`  in  1: FIFO full flag (`wclk` domain).
- `winc`  out  1: FIFO write enable.
- `wdata`  out  DSIZE: FIFO write data.

## Operation
- State machine with two states: IDLE and BURST. Registered state: `owner` index, `last` index, beat counter `beats` (width clog2(MAX_BURST+1)).
- Combinational outputs:
  - `winc = busy & req[owner] & ~wfull & ~wrst`.
  - `wdata` = slice `owner` of `req_data` (all zero when idle).
  - `ack = winc ? (1<<owner) : 0`.
- Arbitration function: scan `req` starting at `last+1` mod NREQ, wrapping; the first set bit wins. The current owner is therefore lowest priority.
- IDLE behaviour:
  - If any `req` bit is set, load `owner` with the winner, clear `beats`, and go to BURST.
  - Otherwise stay in IDLE.
- BURST, per edge:
  - If `winc`, increment `beats`.
  - Release occurs when either:
    - `req[owner]` is low, or
    - `winc` is high and `beats+1 == MAX_BURST`.
  - On release, set `last = owner` and arbitrate on the current `req`, with the releasing owner masked off if its `req` is low.
  - If there is a winner, load it as `owner`, clear `beats`, and stay in BURST (back-to-back handover, no idle cycle). Otherwise go to IDLE.
- `wfull` high stalls the owner: no `winc`, `beats` unchanged, no release due to full, and the owner keeps its grant indefinitely.
- A requester must keep `req` and its data stable until `ack`. Dropping `req` early withdraws the request with no write.
- Each `ack` moves exactly one word; no word is dropped or duplicated.

## Timing
- Reset: `state`=IDLE, `owner`=0, `last`=NREQ-1 (requester 0 has first priority), `beats`=0.
  - All outputs read 0 during the reset cycle and the cycle after: `grant`, `ack`, `busy`, `winc`, `wdata`.
  - Reset asserted mid-burst forces `winc`=0 in that same cycle and returns the block to IDLE at the edge.
- Latency: `req` first seen at edge N in IDLE gives `grant`/`busy` high after edge N. The first `winc`/`ack` occurs in cycle N+1 if `wfull`=0.
- Throughput: one word per cycle, including across grant handovers.
- `wfull` is sampled combinationally the same cycle. The FIFO updates `wfull` at the same edge that consumes `winc`, so consecutive writes up to capacity are safe.
- Simultaneous events:
  - Owner `req` falling in the same cycle `wfull` rises: release on `req` (no write).
  - All requesters dropping at release: go to IDLE.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined:
  - Adds output port `stall_cnt` (16 bits).
  - The counter increments every cycle with `busy & req[owner] & wfull`, saturates at 16'hFFFF, and is cleared by `wrst`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then single requester:
  - Stimulus: `req`=4'b0001 with data 11,22,33,44,55 presented in sequence.
  - Response: first `ack` in the cycle after the `grant` edge. Four acks carry 11..44 to the FIFO; `grant` re-issues to requester 0 with no gap; 55 follows.
- Round-robin:
  - Stimulus: `req`=4'b1111 held, MAX_BURST=4.
  - Response: grant order 0,1,2,3,0, each exactly four acks, with one write per cycle over 20 cycles.
- Full stall:
  - Stimulus: fill the FIFO (ASIZE=4, so 16 words), with the slow read clock paused.
  - Response: `winc`=0 while `wfull`=1, no overflow, the owner keeps its grant, and writes resume on the first cycle `wfull`=0. With `FIFO_WR_ARB_STATS_EN` defined, `stall_cnt` equals the stalled cycles.
- Early drop:
  - Stimulus: requester 2 drops `req` after 1 ack while `req`=4'b0110.
  - Response: handover to requester 1 (wrap from last=2) on the next cycle, with no write for the dropped slot.
- Reset mid-burst:
  - Stimulus: assert `wrst` during beat 2 of requester 1.
  - Response: `winc` is 0 that cycle, all outputs are 0 after the edge, and the next grant goes to requester 0.
- End-to-end scoreboard:
  - Stimulus: 20 random words from 3 requesters.
  - Response: the read side returns every word exactly once, in per-requester order.
